// File: rtl/sb_pkg.sv
// sb_pkg: shared types, field widths and helpers for the sideband TX
// message arbiter (sb_tx_msg_arbiter) and its round-robin picker.
package sb_pkg;

    localparam int SB_STATE_W = 4;
    localparam int SB_MSGNO_W = 4;
    localparam int SB_INFO_W  = 3;
    localparam int SB_DATA_W  = 16;
    localparam int SB_CNT_W   = 8;   // holds BUSY_WAIT_MAX-1 for BUSY_WAIT_MAX up to 255

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        ACK,
        ERR
    } sb_arb_state_e;

    // Message fields captured from the winning requester at grant time.
    typedef struct packed {
        logic [SB_STATE_W-1:0] state;
        logic [SB_STATE_W-1:0] sub_state;
        logic [SB_MSGNO_W-1:0] msg_no;
        logic [SB_INFO_W-1:0]  msg_info;
        logic [SB_DATA_W-1:0]  data;
    } sb_msg_fields_t;

    // Index following idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sb_rr_picker.sv
// sb_rr_picker: combinational round-robin selection. Returns the first set
// request at or after the pointer (wrapping), as one-hot and index, plus
// whether any request is set.
module sb_rr_picker #(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDW-1:0]     o_idx,
    output logic               o_any
);

    logic [IDW-1:0] cand [NUM_REQ];

    // Candidate indices in search order, starting at the pointer.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cand[i] = IDW'((int'(i_ptr) + i) % NUM_REQ);
        end
    end

    // First requesting candidate wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[cand[i]]) begin
                o_any            = 1'b1;
                o_idx            = cand[i];
                o_onehot[cand[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_tx_msg_arbiter.sv
// sb_tx_msg_arbiter: shares the sideband TX message path between NUM_REQ
// training requesters. Round-robin grant, one message in flight, sequenced
// on SB TX busy; per-requester ack on completion, err when SB TX never
// accepts. Optional feature macro SB_ARB_PRIORITY_EN: requester 0 always
// wins when requesting and round-robin covers requesters 1..NUM_REQ-1.
module sb_tx_msg_arbiter
    import sb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BUSY_WAIT_MAX = 15
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_req_data_valid,
    input  logic [SB_STATE_W*NUM_REQ-1:0] i_req_state,
    input  logic [SB_STATE_W*NUM_REQ-1:0] i_req_sub_state,
    input  logic [SB_MSGNO_W*NUM_REQ-1:0] i_req_msg_no,
    input  logic [SB_INFO_W*NUM_REQ-1:0]  i_req_msg_info,
    input  logic [SB_DATA_W*NUM_REQ-1:0]  i_req_data_bus,
    input  logic                          i_hold,
    input  logic                          i_busy,
    output logic                          o_msg_valid,
    output logic                          o_data_valid,
    output logic [SB_STATE_W-1:0]         o_state,
    output logic [SB_STATE_W-1:0]         o_sub_state,
    output logic [SB_MSGNO_W-1:0]         o_msg_no,
    output logic [SB_INFO_W-1:0]          o_msg_info,
    output logic [SB_DATA_W-1:0]          o_data_bus,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [NUM_REQ-1:0]            o_err,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [SB_CNT_W-1:0] CNT_LAST = SB_CNT_W'(BUSY_WAIT_MAX - 1);

    sb_arb_state_e        state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [SB_CNT_W-1:0]  cnt_q, cnt_d;
    sb_msg_fields_t       fields_q, fields_d;
    logic                 msg_valid_q, msg_valid_d;
    logic                 data_valid_q, data_valid_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   err_q, err_d;

    logic [NUM_REQ-1:0]   rr_req;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_any;

    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDW-1:0]       win_idx;
    logic                 win_any;
    logic                 ptr_adv;
    sb_msg_fields_t       win_fields;
    logic                 win_dv;

    sb_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req    (rr_req),
        .i_ptr    (ptr_q),
        .o_onehot (pick_onehot),
        .o_idx    (pick_idx),
        .o_any    (pick_any)
    );

`ifdef SB_ARB_PRIORITY_EN
    // Requester 0 (responses) pre-empts the ring and leaves the pointer alone.
    always_comb begin
        rr_req    = i_req;
        rr_req[0] = 1'b0;
        if (i_req[0]) begin
            win_onehot = NUM_REQ'(1);
            win_idx    = '0;
        end else begin
            win_onehot = pick_onehot;
            win_idx    = pick_idx;
        end
        win_any = i_req[0] | pick_any;
        ptr_adv = !i_req[0];
    end
`else
    // Plain round-robin over every requester.
    always_comb begin
        rr_req     = i_req;
        win_onehot = pick_onehot;
        win_idx    = pick_idx;
        win_any    = pick_any;
        ptr_adv    = 1'b1;
    end
`endif

    // One-hot mux of the winner's message fields and data-valid flag.
    always_comb begin
        win_fields = '0;
        win_dv     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_onehot[k]) begin
                win_fields.state     = i_req_state[k*SB_STATE_W +: SB_STATE_W];
                win_fields.sub_state = i_req_sub_state[k*SB_STATE_W +: SB_STATE_W];
                win_fields.msg_no    = i_req_msg_no[k*SB_MSGNO_W +: SB_MSGNO_W];
                win_fields.msg_info  = i_req_msg_info[k*SB_INFO_W +: SB_INFO_W];
                win_fields.data      = i_req_data_bus[k*SB_DATA_W +: SB_DATA_W];
                win_dv               = i_req_data_valid[k];
            end
        end
    end

    // Transaction FSM next state; pulse outputs are computed here and
    // registered so they coincide with the state they belong to.
    always_comb begin
        // NOTE: every signal written here is defaulted first, so no path can
        // leave it unassigned and infer a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        fields_d     = fields_q;
        msg_valid_d  = 1'b0;
        data_valid_d = 1'b0;
        ack_d        = '0;
        err_d        = '0;
        case (state_q)
            IDLE: begin
                if (win_any && !i_hold && !i_busy) begin
                    state_d      = ISSUE;
                    id_d         = win_idx;
                    fields_d     = win_fields;
                    msg_valid_d  = 1'b1;
                    data_valid_d = win_dv;
                    if (ptr_adv) begin
                        ptr_d = IDW'(rr_next(int'(win_idx), NUM_REQ));
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: begin
                if (i_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                    err_d   = NUM_REQ'(1) << id_q;
                end else begin
                    cnt_d = cnt_q + SB_CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!i_busy) begin
                    state_d = ACK;
                    ack_d   = NUM_REQ'(1) << id_q;
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, latched fields and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            fields_q     <= '0;
            msg_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            ack_q        <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            fields_q     <= fields_d;
            msg_valid_q  <= msg_valid_d;
            data_valid_q <= data_valid_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    assign o_msg_valid  = msg_valid_q;
    assign o_data_valid = data_valid_q;
    assign o_state      = fields_q.state;
    assign o_sub_state  = fields_q.sub_state;
    assign o_msg_no     = fields_q.msg_no;
    assign o_msg_info   = fields_q.msg_info;
    assign o_data_bus   = fields_q.data;
    assign o_ack        = ack_q;
    assign o_err        = err_q;
    assign o_grant_id   = id_q;

endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// tb_sb_tx_msg_arbiter: directed self-checking bench for sb_tx_msg_arbiter.
module tb_sb_tx_msg_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int BUSY_WAIT_MAX = 15;

    localparam logic [15:0] DATA [NUM_REQ] = '{16'h1111, 16'h2222, 16'hA5A5, 16'h3333};
    localparam logic [NUM_REQ-1:0] DV = 4'b0101;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n;
    logic [NUM_REQ-1:0]    i_req;
    logic [NUM_REQ-1:0]    i_req_data_valid;
    logic [4*NUM_REQ-1:0]  i_req_state;
    logic [4*NUM_REQ-1:0]  i_req_sub_state;
    logic [4*NUM_REQ-1:0]  i_req_msg_no;
    logic [3*NUM_REQ-1:0]  i_req_msg_info;
    logic [16*NUM_REQ-1:0] i_req_data_bus;
    logic                  i_hold;
    logic                  i_busy;
    logic                  o_msg_valid;
    logic                  o_data_valid;
    logic [3:0]            o_state;
    logic [3:0]            o_sub_state;
    logic [3:0]            o_msg_no;
    logic [2:0]            o_msg_info;
    logic [15:0]           o_data_bus;
    logic [NUM_REQ-1:0]    o_ack;
    logic [NUM_REQ-1:0]    o_err;
    logic [1:0]            o_grant_id;

    sb_tx_msg_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .BUSY_WAIT_MAX (BUSY_WAIT_MAX)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_req            (i_req),
        .i_req_data_valid (i_req_data_valid),
        .i_req_state      (i_req_state),
        .i_req_sub_state  (i_req_sub_state),
        .i_req_msg_no     (i_req_msg_no),
        .i_req_msg_info   (i_req_msg_info),
        .i_req_data_bus   (i_req_data_bus),
        .i_hold           (i_hold),
        .i_busy           (i_busy),
        .o_msg_valid      (o_msg_valid),
        .o_data_valid     (o_data_valid),
        .o_state          (o_state),
        .o_sub_state      (o_sub_state),
        .o_msg_no         (o_msg_no),
        .o_msg_info       (o_msg_info),
        .o_data_bus       (o_data_bus),
        .o_ack            (o_ack),
        .o_err            (o_err),
        .o_grant_id       (o_grant_id)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  req;
        logic        busy;
        logic [15:0] d2;
        logic        exp_mv;
        logic        exp_dv;
        logic [3:0]  exp_ack;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [3:0] req, input logic busy, input logic [15:0] d2,
                                 input logic mv, input logic dv, input logic [3:0] ack);
        vec_t v;
        v.req = req; v.busy = busy; v.d2 = d2;
        v.exp_mv = mv; v.exp_dv = dv; v.exp_ack = ack;
        return v;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_msg_valid"},  32'(o_msg_valid),  32'd0);
        check({name, "_data_valid"}, 32'(o_data_valid), 32'd0);
        check({name, "_ack"},        32'(o_ack),        32'd0);
        check({name, "_err"},        32'(o_err),        32'd0);
        check({name, "_grant_id"},   32'(o_grant_id),   32'd0);
        check({name, "_state"},      32'(o_state),      32'd0);
        check({name, "_sub_state"},  32'(o_sub_state),  32'd0);
        check({name, "_msg_no"},     32'(o_msg_no),     32'd0);
        check({name, "_msg_info"},   32'(o_msg_info),   32'd0);
        check({name, "_data_bus"},   32'(o_data_bus),   32'd0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_req   = '0;
        i_hold  = 1'b0;
        i_busy  = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
    endtask

    // Waits a bounded number of cycles for the msg_valid pulse.
    task automatic wait_msg(input string name, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            step();
            seen = o_msg_valid;
        end
        check({name, "_msg_seen"}, 32'(seen), 32'd1);
    endtask

    // Busy handshake after the pulse, then expects exactly one-hot ack.
    task automatic finish_txn(input string name, input int exp_id);
        bit got_ack;
        int msgs;
        msgs   = 0;
        i_busy = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            if (o_msg_valid) msgs++;
        end
        i_busy  = 1'b0;
        got_ack = 1'b0;
        for (int n = 0; n < 6 && !got_ack; n++) begin
            step();
            if (o_msg_valid) msgs++;
            got_ack = (o_ack != '0);
        end
        check({name, "_ack_seen"},  32'(got_ack), 32'd1);
        check({name, "_ack"},       32'(o_ack),   32'(4'b0001 << exp_id));
        check({name, "_no_err"},    32'(o_err),   32'd0);
        check({name, "_extra_msg"}, 32'(msgs),    32'd0);
    endtask

    task automatic do_txn(input string name, input int exp_id);
        bit seen;
        wait_msg(name, seen);
        if (seen) begin
            check({name, "_grant_id"},   32'(o_grant_id),   32'(exp_id));
            check({name, "_data_valid"}, 32'(o_data_valid), 32'(DV[exp_id]));
            check({name, "_data_bus"},   32'(o_data_bus),   32'(DATA[exp_id]));
            finish_txn(name, exp_id);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int cnt;
        bit got;
        int acks;

        i_rst_n          = 1'b1;
        i_req            = '0;
        i_hold           = 1'b0;
        i_busy           = 1'b0;
        i_req_data_valid = DV;
        i_req_state      = 16'h4321;
        i_req_sub_state  = 16'h8765;
        i_req_msg_no     = 16'hCBA9;
        i_req_msg_info   = 12'b101_110_011_001;
        i_req_data_bus   = {DATA[3], DATA[2], DATA[1], DATA[0]};

        // Async reset assertion before any clock edge.
        #2 i_rst_n = 1'b0;
        #1 check_all_zero("reset");
        step();
        step();
        i_rst_n = 1'b1;

        // Single requester 2 with data; busy rises two cycles after the pulse.
        vecs[0] = mkv(4'b0100, 1'b0, 16'hA5A5, 1'b1, 1'b1, 4'b0000);
        vecs[1] = mkv(4'b0100, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);
        for (int c = 2; c < 12; c++) vecs[c] = mkv(4'b0100, 1'b1, 16'h0000, 1'b0, 1'b0, 4'b0000);
        vecs[12] = mkv(4'b0100, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0100);
        vecs[13] = mkv(4'b0000, 1'b0, 16'hA5A5, 1'b0, 1'b0, 4'b0000);
        vecs[14] = mkv(4'b0000, 1'b0, 16'hA5A5, 1'b0, 1'b0, 4'b0000);

        for (int c = 0; c < 15; c++) begin
            i_req                 = vecs[c].req;
            i_busy                = vecs[c].busy;
            i_req_data_bus[47:32] = vecs[c].d2;
            step();
            check($sformatf("v%0d_msg_valid", c),  32'(o_msg_valid),  32'(vecs[c].exp_mv));
            check($sformatf("v%0d_data_valid", c), 32'(o_data_valid), 32'(vecs[c].exp_dv));
            check($sformatf("v%0d_ack", c),        32'(o_ack),        32'(vecs[c].exp_ack));
            check($sformatf("v%0d_err", c),        32'(o_err),        32'd0);
            check($sformatf("v%0d_data_bus", c),   32'(o_data_bus),   32'hA5A5);
            check($sformatf("v%0d_grant_id", c),   32'(o_grant_id),   32'd2);
        end
        check("v_state",     32'(o_state),     32'h3);
        check("v_sub_state", 32'(o_sub_state), 32'h7);
        check("v_msg_no",    32'(o_msg_no),    32'hB);
        check("v_msg_info",  32'(o_msg_info),  32'h6);

        // All four requesting from pointer 0: 0,1,2,3,0.
        do_reset();
        i_req = 4'b1111;
        do_txn("rr0", 0);
        do_txn("rr1", 1);
        do_txn("rr2", 2);
        do_txn("rr3", 3);
        do_txn("rr4", 0);
        i_req = '0;

        // SB TX never goes busy: err on requester 3, no ack.
        i_req = 4'b1000;
        wait_msg("tmo", seen);
        if (seen) begin
            cnt  = 0;
            got  = 1'b0;
            acks = 0;
            for (int n = 1; n <= 40 && !got; n++) begin
                step();
                if (o_ack != '0) acks++;
                if (o_err != '0) begin
                    got = 1'b1;
                    cnt = n;
                end
            end
            check("tmo_err_seen", 32'(got),   32'd1);
            check("tmo_latency",  32'(cnt),   32'(BUSY_WAIT_MAX + 1));
            check("tmo_err",      32'(o_err), 32'b1000);
            check("tmo_no_ack",   32'(acks),  32'd0);
            i_req = '0;
            step();
            check("tmo_err_pulse", 32'(o_err), 32'd0);
        end

        // Hold blocks the grant; release grants on the next edge.
        i_hold = 1'b1;
        i_req  = 4'b0010;
        cnt    = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (o_msg_valid) cnt++;
        end
        check("hold_blocked", 32'(cnt), 32'd0);
        i_hold = 1'b0;
        step();
        check("hold_release_msg", 32'(o_msg_valid), 32'd1);
        check("hold_grant_id",    32'(o_grant_id),  32'd1);
        // Hold raised mid-transaction does not stop completion.
        i_hold = 1'b1;
        finish_txn("hold_mid", 1);
        i_req  = '0;
        i_hold = 1'b0;

        // Busy high in IDLE blocks the grant.
        i_busy = 1'b1;
        i_req  = 4'b0100;
        cnt    = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (o_msg_valid) cnt++;
        end
        check("busy_idle_blocked", 32'(cnt), 32'd0);
        i_busy = 1'b0;
        step();
        check("busy_idle_msg",      32'(o_msg_valid), 32'd1);
        check("busy_idle_grant_id", 32'(o_grant_id),  32'd2);
        // Reach WAIT_DONE, then reset asynchronously.
        i_busy = 1'b1;
        step();
        step();
        #2 i_rst_n = 1'b0;
        #1 check_all_zero("midrst");
        i_busy = 1'b0;
        i_req  = '0;
        step();
        i_rst_n = 1'b1;
        acks    = 0;
        for (int n = 0; n < 3; n++) begin
            step();
            if (o_ack != '0 || o_err != '0) acks++;
        end
        check("midrst_no_ack", 32'(acks), 32'd0);
        i_req = 4'b1111;
        do_txn("post_rst", 0);
        i_req = '0;

`ifdef SB_ARB_PRIORITY_EN
        // Requester 0 jumps the ring without moving the pointer.
        do_reset();
        i_req = 4'b1110;
        wait_msg("prio_a", seen);
        if (seen) begin
            check("prio_a_grant_id", 32'(o_grant_id), 32'd1);
            i_req[0] = 1'b1;
            finish_txn("prio_a", 1);
            i_req[1] = 1'b0;
            do_txn("prio_b", 0);
            i_req[0] = 1'b0;
            do_txn("prio_c", 2);
        end
        i_req = '0;
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
